// File: rtl/seq_dtree_eval_if.sv
// Handshake and configuration bundle for the sequential decision-tree evaluator.
// The slave side is the evaluator; the master side drives features, config and out_ready.
interface seq_dtree_eval_if #(
   parameter int N_FEAT    = 4,
   parameter int FEAT_W    = 8,
   parameter int CLASS_W   = 4,
   parameter int N_NODES   = 16,
   parameter int MAX_DEPTH = 8
) ();
   localparam int NA_W  = $clog2(N_NODES);
   localparam int FI_W  = $clog2(N_FEAT);
   localparam int CFG_W = 1 + FI_W + FEAT_W + 2 * NA_W;
   localparam int DEP_W = $clog2(MAX_DEPTH + 1);

   logic                     cfg_we;
   logic [NA_W-1:0]          cfg_addr;
   logic [CFG_W-1:0]         cfg_wdata;
   logic                     cfg_busy;
   logic                     in_valid;
   logic                     in_ready;
   logic [N_FEAT*FEAT_W-1:0] in_feat;
   logic                     out_valid;
   logic                     out_ready;
   logic [CLASS_W-1:0]       out_class;
   logic                     out_err;
   logic [DEP_W-1:0]         out_depth;

   modport slave (
      input  cfg_we, cfg_addr, cfg_wdata, in_valid, in_feat, out_ready,
      output cfg_busy, in_ready, out_valid, out_class, out_err, out_depth
   );

   modport master (
      output cfg_we, cfg_addr, cfg_wdata, in_valid, in_feat, out_ready,
      input  cfg_busy, in_ready, out_valid, out_class, out_err, out_depth
   );
endinterface

// File: rtl/seq_dtree_eval.sv
// Sequential decision-tree evaluator: walks a register node table one node per cycle
// from entry 0 until a leaf, a depth overflow or an out-of-range child ends the walk.
module seq_dtree_eval #(
   parameter int N_FEAT    = 4,
   parameter int FEAT_W    = 8,
   parameter int CLASS_W   = 4,
   parameter int N_NODES   = 16,
   parameter int MAX_DEPTH = 8
) (
   input logic            clk,
   input logic            rst_n,
   seq_dtree_eval_if.slave bus
);
   localparam int NA_W  = $clog2(N_NODES);
   localparam int FI_W  = $clog2(N_FEAT);
   localparam int DEP_W = $clog2(MAX_DEPTH + 1);
   localparam int ENT_W = 1 + FI_W + FEAT_W + 2 * NA_W;

   typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

   state_t             state_q, state_nxt;
   logic [ENT_W-1:0]   tbl_q [N_NODES];
   logic [FEAT_W-1:0]  feat_q [N_FEAT];
   logic [NA_W-1:0]    node_q;
   logic [DEP_W-1:0]   depth_q;
   logic [CLASS_W-1:0] class_q;
   logic               err_q;
   logic [DEP_W-1:0]   odepth_q;

   logic               ent_leaf;
   logic [FI_W-1:0]    ent_fi;
   logic [FEAT_W-1:0]  ent_thr;
   logic [NA_W-1:0]    ent_t, ent_f;
   logic [NA_W-1:0]    child;
   logic [FEAT_W-1:0]  fsel;
   logic               accept, cfg_wr;
   logic               walk_leaf, walk_abort, walk_step;

   assign {ent_leaf, ent_fi, ent_thr, ent_t, ent_f} = tbl_q[node_q];

   assign accept = (state_q == IDLE) && bus.in_valid;
   assign cfg_wr = (state_q == IDLE) && bus.cfg_we && (int'(bus.cfg_addr) < N_NODES);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_nxt;
   end

   always_comb begin
      state_nxt     = state_q;
      walk_leaf     = 1'b0;
      walk_abort    = 1'b0;
      walk_step     = 1'b0;
      fsel          = (int'(ent_fi) < N_FEAT) ? feat_q[ent_fi] : '0;
      child         = (fsel <= ent_thr) ? ent_t : ent_f;
      bus.in_ready  = (state_q == IDLE);
      bus.cfg_busy  = (state_q != IDLE);
      bus.out_valid = (state_q == DONE);
      bus.out_class = class_q;
      bus.out_err   = err_q;
      bus.out_depth = odepth_q;
      case (state_q)
         IDLE: if (bus.in_valid) state_nxt = WALK;
         WALK: begin
            if (ent_leaf) begin
               walk_leaf = 1'b1;
               state_nxt = DONE;
            end else if ((depth_q == DEP_W'(MAX_DEPTH)) || (int'(child) >= N_NODES)) begin
               // Both abort causes report the depth reached so far, which is MAX_DEPTH for overflow
               walk_abort = 1'b1;
               state_nxt  = DONE;
            end else begin
               walk_step = 1'b1;
            end
         end
         DONE: if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Node table: every entry comes out of reset as a class-0 leaf
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_NODES; i++) tbl_q[i] <= {1'b1, {(ENT_W-1){1'b0}}};
      end else if (cfg_wr) begin
         tbl_q[bus.cfg_addr] <= bus.cfg_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         for (int j = 0; j < N_FEAT; j++) feat_q[j] <= bus.in_feat[j*FEAT_W +: FEAT_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         node_q   <= '0;
         depth_q  <= '0;
         class_q  <= '0;
         err_q    <= 1'b0;
         odepth_q <= '0;
      end else begin
         if (accept) begin
            node_q  <= '0;
            depth_q <= '0;
         end
         if (walk_step) begin
            node_q  <= child;
            depth_q <= depth_q + DEP_W'(1);
         end
         if (walk_leaf) begin
            class_q  <= ent_thr[CLASS_W-1:0];
            err_q    <= 1'b0;
            odepth_q <= depth_q;
         end
         if (walk_abort) begin
            class_q  <= '0;
            err_q    <= 1'b1;
            odepth_q <= depth_q;
         end
      end
   end
endmodule

// File: tb/tb_seq_dtree_eval.sv
// Scoreboard bench for seq_dtree_eval: stimulus pushes expected results, a monitor
// compares every cycle the DUT presents out_valid and pops on handshake.
module tb_seq_dtree_eval;
   localparam int N_FEAT = 4, FEAT_W = 8, CLASS_W = 4, N_NODES = 16, MAX_DEPTH = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seq_dtree_eval_if #(.N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .CLASS_W(CLASS_W),
                       .N_NODES(N_NODES), .MAX_DEPTH(MAX_DEPTH)) bus ();

   seq_dtree_eval #(.N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .CLASS_W(CLASS_W),
                    .N_NODES(N_NODES), .MAX_DEPTH(MAX_DEPTH)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   typedef struct {int cls; int err; int dep; int lat; int acc;} exp_t;
   exp_t sb[$];

   int n_chk = 0, n_fail = 0, cyc = 0, ready_mode = 0;
   bit prev_valid = 1'b0;

   logic       m_leaf [N_NODES];
   logic [1:0] m_fi   [N_NODES];
   logic [7:0] m_thr  [N_NODES];
   logic [3:0] m_t    [N_NODES];
   logic [3:0] m_f    [N_NODES];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void mirror_reset();
      for (int i = 0; i < N_NODES; i++) begin
         m_leaf[i] = 1'b1; m_fi[i] = '0; m_thr[i] = '0; m_t[i] = '0; m_f[i] = '0;
      end
   endfunction

   function automatic void model(input logic [31:0] feat, output int cls, output int err,
                                 output int dep);
      int node;
      logic [7:0] v;
      node = 0; cls = 0; err = 0; dep = 0;
      for (int i = 0; i <= MAX_DEPTH; i++) begin
         if (m_leaf[node]) begin
            cls = int'(m_thr[node][3:0]);
            return;
         end
         if (dep == MAX_DEPTH) begin
            err = 1; cls = 0;
            return;
         end
         v = feat[int'(m_fi[node])*8 +: 8];
         node = (v <= m_thr[node]) ? int'(m_t[node]) : int'(m_f[node]);
         dep++;
      end
   endfunction

   // Monitor: every valid cycle must match the head of the scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
               chk("spurious out_valid", int'(bus.out_valid), 0);
            end else begin
               if (!prev_valid) chk("latency", cyc - sb[0].acc, sb[0].lat);
               chk("out_class", int'(bus.out_class), sb[0].cls);
               chk("out_err", int'(bus.out_err), sb[0].err);
               chk("out_depth", int'(bus.out_depth), sb[0].dep);
               if (bus.out_ready === 1'b1) void'(sb.pop_front());
            end
         end
         prev_valid = (bus.out_valid === 1'b1);
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'b0;
            default: bus.out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic cfg_write(input int addr, input int leaf, input int fi, input int thr,
                            input int t, input int f, input bit take);
      @(negedge clk);
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = addr[3:0];
      bus.cfg_wdata = {leaf[0], fi[1:0], thr[7:0], t[3:0], f[3:0]};
      @(posedge clk);
      #1 bus.cfg_we = 1'b0;
      if (take) begin
         m_leaf[addr] = leaf[0]; m_fi[addr] = fi[1:0]; m_thr[addr] = thr[7:0];
         m_t[addr] = t[3:0]; m_f[addr] = f[3:0];
      end
   endtask

   task automatic send(input bit sync, input logic [31:0] feat, input int cls, input int err,
                       input int dep, input int lat);
      int n;
      exp_t e;
      n = 0;
      if (sync) @(negedge clk);
      bus.in_feat  = feat;
      bus.in_valid = 1'b1;
      while (bus.in_ready !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) begin
         chk("in_ready timeout", int'(bus.in_ready), 1);
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      e.cls = cls; e.err = err; e.dep = dep; e.lat = lat; e.acc = cyc;
      sb.push_back(e);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((sb.size() != 0 || bus.out_valid === 1'b1) && n < 3000);
      if (n >= 3000) chk("drain timeout", sb.size(), 0);
   endtask

   task automatic prog_tree();
      cfg_write(0, 0, 0, 100, 1, 2, 1);
      cfg_write(1, 0, 1,  50, 3, 4, 1);
      cfg_write(2, 1, 0,   2, 0, 0, 1);
      cfg_write(3, 0, 2, 200, 5, 6, 1);
      cfg_write(4, 1, 0,   4, 0, 0, 1);
      cfg_write(5, 0, 3,  10, 7, 8, 1);
      cfg_write(6, 1, 0,   6, 0, 0, 1);
      cfg_write(7, 1, 0,   7, 0, 0, 1);
      cfg_write(8, 1, 0,   8, 0, 0, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cls, err, dep;
      logic [31:0] feat;
      bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
      bus.in_valid = 1'b0; bus.in_feat = '0; bus.out_ready = 1'b1;
      mirror_reset();

      repeat (3) @(posedge clk);
      #1;
      chk("reset out_valid", int'(bus.out_valid), 0);
      chk("reset cfg_busy", int'(bus.cfg_busy), 0);
      chk("reset out_class", int'(bus.out_class), 0);
      chk("reset out_err", int'(bus.out_err), 0);
      chk("reset out_depth", int'(bus.out_depth), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("reset in_ready", int'(bus.in_ready), 1);

      // Untouched table: root is a class-0 leaf
      send(1, 32'h12345678, 0, 0, 0, 1);
      send(1, 32'hFFFFFFFF, 0, 0, 0, 1);
      wait_idle();

      cfg_write(0, 0, 1, 63, 1, 2, 1);
      cfg_write(1, 1, 0, 5, 0, 0, 1);
      cfg_write(2, 1, 0, 9, 0, 0, 1);
      send(1, 32'h00003F00, 5, 0, 1, 2);
      send(1, 32'h00004000, 9, 0, 1, 2);
      send(1, 32'hFF0000FF, 5, 0, 1, 2);
      wait_idle();

      // Backpressure: result held, busy, config write and new input ignored
      ready_mode = 1;
      send(1, 32'h00003F00, 5, 0, 1, 2);
      while (bus.out_valid !== 1'b1) @(negedge clk);
      cfg_write(1, 1, 0, 3, 0, 0, 0);
      bus.in_feat  = 32'h00004000;
      bus.in_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("hold in_ready", int'(bus.in_ready), 0);
         chk("hold cfg_busy", int'(bus.cfg_busy), 1);
      end
      bus.in_valid = 1'b0;
      ready_mode = 0;
      wait_idle();
      send(1, 32'h00003F00, 5, 0, 1, 2);
      wait_idle();

      // Config write and accept on the same edge: walk sees the new entry
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = 4'd1;
      bus.cfg_wdata = {1'b1, 2'd0, 8'd11, 4'd0, 4'd0};
      send(0, 32'h00003F00, 11, 0, 1, 2);
      bus.cfg_we = 1'b0;
      m_thr[1] = 8'd11;
      wait_idle();

      cfg_write(0, 0, 0, 255, 0, 0, 1);
      send(1, 32'h000000AB, 0, 1, 8, 9);
      wait_idle();

      prog_tree();
      send(1, 32'h00FA140A, 6, 0, 3, 4);
      send(1, 32'h0AC8140A, 7, 0, 4, 5);
      send(1, 32'h00000065, 2, 0, 1, 2);
      wait_idle();

      // Reset in the middle of a depth-3 walk
      @(negedge clk);
      bus.in_feat  = 32'h00FA140A;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midreset out_valid", int'(bus.out_valid), 0);
      chk("midreset in_ready", int'(bus.in_ready), 1);
      chk("midreset cfg_busy", int'(bus.cfg_busy), 0);
      mirror_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("postreset out_valid", int'(bus.out_valid), 0);
      end
      chk("postreset in_ready", int'(bus.in_ready), 1);
      send(1, 32'h00FA140A, 0, 0, 0, 1);
      wait_idle();

      prog_tree();
      ready_mode = 2;
      for (int i = 0; i < 100; i++) begin
         feat = {8'($urandom_range(0, 20)), 8'($urandom_range(150, 255)),
                 8'($urandom_range(0, 100)), 8'($urandom_range(0, 150))};
         model(feat, cls, err, dep);
         send(1, feat, cls, err, dep, dep + 1);
      end
      ready_mode = 0;
      wait_idle();
      chk("scoreboard empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/seq_dtree_eval.md
SEQ_DTREE_EVAL -- requirements
Module: seq_dtree_eval

Interface
REQ-001 Parameter N_FEAT, default 4, number of input features.
REQ-002 Parameter FEAT_W, default 8, bits per feature and per threshold.
REQ-003 Parameter CLASS_W, default 4, class label width (CLASS_W <= FEAT_W).
REQ-004 Parameter N_NODES, default 16, node-table entries; NA_W = clog2(N_NODES), FI_W = clog2(N_FEAT).
REQ-005 Parameter MAX_DEPTH, default 8, maximum internal nodes visited per inference.
REQ-006 clk  in  1  single clock; all state changes on the rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 cfg_we  in  1  node-table write strobe.
REQ-009 cfg_addr  in  NA_W  node index to write.
REQ-010 cfg_wdata  in  1+FI_W+FEAT_W+2*NA_W  {leaf, feat_idx, thr, t_child, f_child}, MSB first.
REQ-011 cfg_busy  out  1  high whenever the FSM is not IDLE.
REQ-012 in_valid / in_ready  in / out  1 / 1  feature-vector handshake.
REQ-013 in_feat  in  N_FEAT*FEAT_W  feature j at bits [j*FEAT_W +: FEAT_W].
REQ-014 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-015 out_class  out  CLASS_W  predicted class.
REQ-016 out_err  out  1  walk aborted (depth overflow or illegal child index).
REQ-017 out_depth  out  clog2(MAX_DEPTH+1)  internal nodes traversed for this result.

Function
REQ-018 The block SHALL hold an N_NODES-entry register node table; root is always entry 0.
REQ-019 An internal node SHALL route to t_child when unsigned in_feat[feat_idx] <= thr, else to f_child.
REQ-020 A leaf node (leaf=1) SHALL yield class = thr[CLASS_W-1:0]; its other fields are ignored.
REQ-021 FSM states SHALL be IDLE, WALK, DONE; IDLE->WALK on in_valid&&in_ready, WALK->DONE on leaf or abort, DONE->IDLE on out_valid&&out_ready.
REQ-022 in_ready SHALL equal (state==IDLE); in_feat SHALL be captured on the accepting edge and held for the whole walk.
REQ-023 In WALK the block SHALL evaluate exactly one node per cycle, starting at entry 0, incrementing a depth counter per internal node.
REQ-024 out_valid SHALL rise exactly k+1 edges after the accepting edge, k = internal nodes on the path (leaf at root: 1 edge).
REQ-025 If an internal node is evaluated with depth already == MAX_DEPTH, the walk SHALL abort: out_err=1, out_class=0, out_depth=MAX_DEPTH.
REQ-026 A child index >= N_NODES SHALL abort the walk on that node: out_err=1, out_class=0, out_depth=depth at abort.
REQ-027 out_class, out_err, out_depth SHALL be stable while out_valid is high and out_ready low.
REQ-028 cfg_we SHALL update the table only when state==IDLE; writes while cfg_busy=1 SHALL be dropped silently.
REQ-029 A cfg write and an input accept on the same edge SHALL both take effect; the walk SHALL use the newly written entry.
REQ-030 in_valid while busy SHALL not be accepted and SHALL not affect the current walk.

Reset
REQ-031 On rst_n low the FSM SHALL go to IDLE immediately, including mid-walk or in DONE; the pending result SHALL be discarded.
REQ-032 Reset values: out_valid=0, out_class=0, out_err=0, out_depth=0, cfg_busy=0, in_ready=1 once rst_n is high.
REQ-033 Every table entry SHALL reset to leaf=1, thr=0 (class 0), all other fields 0.

Verification (N_FEAT=4, FEAT_W=8, CLASS_W=4, N_NODES=16, MAX_DEPTH=8)
REQ-034 Program n0={0,1,63,1,2}, n1 leaf class 5, n2 leaf class 9; feat1=63 -> class 5, err 0, depth 1, out_valid 2 edges after accept; feat1=64 -> class 9.
REQ-035 After reset with no cfg writes, any input -> class 0, err 0, depth 0, out_valid 1 edge after accept.
REQ-036 n0={0,0,255,0,0} (self-loop) -> out_err=1, class 0, depth 8, out_valid 9 edges after accept.
REQ-037 Hold out_ready=0 for 5 cycles with class 5 pending -> outputs stable, in_ready=0, cfg write to n1 dropped; after release next inference still returns 5.
REQ-038 Assert rst_n low during WALK of a depth-3 path -> out_valid stays 0, in_ready=1 after release, next inference correct.
REQ-039 Stream 100 random vectors through a depth-4 programmed tree with random out_ready -> every result matches a software tree model, none lost or duplicated.
